player_trail_gen: RTL and testbench
===================================

# player_trail_gen

Generates the player's trail particle field consumed by `vga_screen_pic` (`trail_x`, `trail_y`, `trail_life`, 41 entries). Once per video frame it spawns a particle at the player's current position, ages every live particle and drifts it left. It sits between the game-logic block (`gamemode`, `player_y`) and the renderer. All outputs are registered, so the field is stable for a whole frame.

## Interface
Parameters:
- `N_TRAIL`, 41, particle slots; must match the renderer's array depth.
- `LIFE_MAX`, 10, life assigned at spawn; the renderer's colour table covers 1..10.
- `TRAIL_SPEED`, 4, leftward pixels per frame.
- `SPAWN_DIV`, 1, spawn once every `SPAWN_DIV` frame ticks in play mode (1..15).

Ports:
- `clk` in 1: pixel clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, issued during vertical blanking.
- `gamemode` in 2: 00 start, 01 play, 10 pause, 11 game over.
- `player_y` in 9: player sprite top row.
- `trail_x` out [N_TRAIL-1:0][9:0]: particle centre x.
- `trail_y` out [N_TRAIL-1:0][8:0]: particle centre y.
- `trail_life` out [N_TRAIL-1:0][3:0]: 0 means dead; otherwise alpha 1..10.

## Operation
- State:
  - per-slot x/y/life registers;
  - write pointer `wr_ptr` (0..N_TRAIL-1);
  - spawn counter `spawn_cnt` (4 bit);
  - 4-bit LFSR `lfsr`, polynomial x^4+x^3+1.
- Mode 00 (start): every cycle, all life ← 0, `wr_ptr` ← 0, `spawn_cnt` ← 0. Whether `frame_tick` is high does not matter. x, y and `lfsr` hold.
- Mode 10 (pause): all state frozen; `frame_tick` is ignored.
- Mode 01 (play), on `frame_tick`, for every slot with life>0:
  - if x < TRAIL_SPEED, life ← 0 (no wrap-around);
  - otherwise x ← x − TRAIL_SPEED and life ← life − 1.
  - Then, if `spawn_cnt` == SPAWN_DIV−1, spawn into slot `wr_ptr`:
    - life ← LIFE_MAX;
    - x ← PLAYER_X;
    - y ← clamp(player_y + PLAYER_SIZE/2 − 4 + lfsr[2:0], UPPER_BOUND+1, LOWER_BOUND−1);
    - `wr_ptr` ← (`wr_ptr` == N_TRAIL−1) ? 0 : `wr_ptr`+1;
    - `lfsr` steps; `spawn_cnt` ← 0.
  - If no spawn occurs, `spawn_cnt` increments.
- Mode 11 (game over), on `frame_tick`: same ageing and drift as play mode; no spawn; `spawn_cnt`, `wr_ptr` and `lfsr` hold. The trail fades out within LIFE_MAX frames.
- Spawn and age hitting the same slot in one tick: the spawn wins. The overwritten slot gets fresh values and does not also decrement.
- Arithmetic:
  - y sum computed at 10 bits before clamping; no truncation.
  - x compare is unsigned 10-bit.
  - `lfsr` never reaches 0.

## Timing
- Reset values: every `trail_x`, `trail_y` and `trail_life` = 0; `wr_ptr` = 0; `spawn_cnt` = 0; `lfsr` = 4'b1001.
- Latency: state updates on the rising `clk` edge where `frame_tick`=1. The new field is visible one cycle later and holds until the next tick.
- `gamemode` and `player_y` are sampled on the tick edge.
- A mode change to 00 clears lives on the next edge.
- Reset asserted mid-frame clears all outputs immediately; outputs stay 0 until the first play-mode tick after `rst_n` deasserts.

## Structure
- Shared package `game_pkg`:
  - gamemode constants `GM_START`, `GM_PLAY`, `GM_PAUSE`, `GM_OVER`;
  - `PLAYER_X`=160, `PLAYER_SIZE`=40, `UPPER_BOUND`=20, `LOWER_BOUND`=460, `LIFE_MAX`=10.
  - The renderer imports the same package.
- Sub-module `trail_lfsr`: 4-bit LFSR with `clk`, `rst_n`, `step` and `q` ports; seed is a parameter.

## Test plan
- Reset, then mode 01, `player_y`=200, one tick → slot 0 = (x 160, y 217, life 10), since lfsr[2:0]=001. All other slots have life 0 and `wr_ptr`=1.
- Continue 5 ticks, `player_y` fixed → slot 0 reads x 140, life 5. Slots 1..5 hold x 144, 148, 152, 156, 160 with lives 6..10.
- 45 ticks in play mode → `wr_ptr` wraps 40→0. Slot 0 is overwritten with life 10 and is not decremented. At most 10 slots are live.
- 3 ticks in play mode, then switch to 10 with 4 ticks → field unchanged. Switch to 11 with 10 ticks → every life = 0 and no new spawns.
- `player_y`=0 on spawn → y = 21. `player_y`=511 on spawn → y = 459.
- A particle with x=2 at a tick → life 0 and x unchanged. Separately, `rst_n` pulsed low mid-frame → all outputs 0 asynchronously.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: gamemode encodings, playfield geometry and trail spawn helper.
// Latency: none (constants and a pure function).
// Backpressure: not applicable.
package game_pkg;

  // Gamemode encodings driven by the game-logic block
  localparam logic [1:0] GM_START = 2'b00;
  localparam logic [1:0] GM_PLAY  = 2'b01;
  localparam logic [1:0] GM_PAUSE = 2'b10;
  localparam logic [1:0] GM_OVER  = 2'b11;

  // Playfield geometry shared with the renderer
  localparam int PLAYER_X    = 160;
  localparam int PLAYER_SIZE = 40;
  localparam int UPPER_BOUND = 20;
  localparam int LOWER_BOUND = 460;
  localparam int LIFE_MAX    = 10;

  // Spawn row: sprite centre minus 4 plus a 0..7 jitter, kept strictly inside the
  // playfield bounds. The sum is formed at 10 bits so player_y near 511 cannot wrap.
  function automatic logic [8:0] spawn_y(input logic [8:0] py, input logic [2:0] rnd);
    logic [9:0] sum;
    sum = {1'b0, py} + 10'(PLAYER_SIZE / 2 - 4) + {7'd0, rnd};
    if (sum < 10'(UPPER_BOUND + 1)) begin
      spawn_y = 9'(UPPER_BOUND + 1);
    end else if (sum > 10'(LOWER_BOUND - 1)) begin
      spawn_y = 9'(LOWER_BOUND - 1);
    end else begin
      spawn_y = sum[8:0];
    end
  endfunction

endpackage

// File: rtl/player_trail_gen_if.sv
// Bundle between game logic / renderer and the trail generator.
// Latency: none (wires only).
// Backpressure: none; the trail field is a level-held broadcast.
interface player_trail_gen_if #(
  parameter int N_TRAIL = 41
);
  logic                       frame_tick;
  logic [1:0]                 gamemode;
  logic [8:0]                 player_y;
  logic [N_TRAIL-1:0][9:0]    trail_x;
  logic [N_TRAIL-1:0][8:0]    trail_y;
  logic [N_TRAIL-1:0][3:0]    trail_life;

  // Game-logic side: drives frame/mode/player, observes the field
  modport master (
    output frame_tick, gamemode, player_y,
    input  trail_x, trail_y, trail_life
  );

  // Trail generator side
  modport slave (
    input  frame_tick, gamemode, player_y,
    output trail_x, trail_y, trail_life
  );
endinterface

// File: rtl/trail_lfsr.sv
// 4-bit Fibonacci LFSR, x^4+x^3+1, used as spawn jitter; cycles through all 15 nonzero states.
// Latency: q advances on the clk edge where step=1.
// Backpressure: none; step is a plain enable.
module trail_lfsr #(
  parameter logic [3:0] SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [3:0] q
);

  // Shift left, feeding back taps 4 and 3; a nonzero seed never reaches all-zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[2:0], q[3] ^ q[2]};
    end
  end

endmodule

// File: rtl/player_trail_gen.sv
// Per-frame player trail particle field: spawn at player, age and drift left each frame_tick.
// Latency: field updates on the tick edge, visible next cycle and held until the next tick.
// Backpressure: none; the renderer samples the registered field whenever it likes.
module player_trail_gen #(
  parameter int N_TRAIL     = 41,
  parameter int LIFE_MAX    = game_pkg::LIFE_MAX,
  parameter int TRAIL_SPEED = 4,
  parameter int SPAWN_DIV   = 1
) (
  input logic               clk,
  input logic               rst_n,
  player_trail_gen_if.slave bus
);
  import game_pkg::*;

  localparam int         PTR_W = $clog2(N_TRAIL);
  localparam logic [9:0] SPEED = 10'(TRAIL_SPEED);

  logic [N_TRAIL-1:0][9:0] x_q, x_d;
  logic [N_TRAIL-1:0][8:0] y_q, y_d;
  logic [N_TRAIL-1:0][3:0] life_q, life_d;
  logic [PTR_W-1:0]        wr_ptr;
  logic [3:0]              spawn_cnt;
  logic [3:0]              lfsr_q;
  logic                    unused_lfsr_msb;

  logic mode_start, mode_play, mode_over;
  logic age_en, spawn_en;

  assign mode_start = (bus.gamemode == GM_START);
  assign mode_play  = (bus.gamemode == GM_PLAY);
  assign mode_over  = (bus.gamemode == GM_OVER);

  // Pause falls through every enable, freezing all state
  assign age_en   = bus.frame_tick && (mode_play || mode_over);
  assign spawn_en = bus.frame_tick && mode_play && (spawn_cnt == 4'(SPAWN_DIV - 1));

  // Only the low three LFSR bits feed the jitter
  assign unused_lfsr_msb = lfsr_q[3];

  trail_lfsr #(
    .SEED (4'b1001)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (spawn_en),
    .q     (lfsr_q)
  );

  // Next field: age/drift live slots, then let a spawn overwrite its slot, start mode kills all
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    life_d = life_q;
    if (age_en) begin
      for (int i = 0; i < N_TRAIL; i++) begin
        if (life_q[i] != 4'd0) begin
          // Particles reaching the left edge die in place rather than wrapping
          if (x_q[i] < SPEED) begin
            life_d[i] = 4'd0;
          end else begin
            x_d[i]    = x_q[i] - SPEED;
            life_d[i] = life_q[i] - 4'd1;
          end
        end
      end
    end
    if (spawn_en) begin
      x_d[wr_ptr]    = 10'(PLAYER_X);
      y_d[wr_ptr]    = spawn_y(bus.player_y, lfsr_q[2:0]);
      life_d[wr_ptr] = 4'(LIFE_MAX);
    end
    if (mode_start) begin
      life_d = '0;
    end
  end

  // Particle field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      life_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      life_q <= life_d;
    end
  end

  // Ring write pointer and spawn-rate divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      spawn_cnt <= 4'd0;
    end else if (mode_start) begin
      wr_ptr    <= '0;
      spawn_cnt <= 4'd0;
    end else if (spawn_en) begin
      wr_ptr    <= (wr_ptr == PTR_W'(N_TRAIL - 1)) ? '0 : wr_ptr + 1'b1;
      spawn_cnt <= 4'd0;
    end else if (bus.frame_tick && mode_play) begin
      spawn_cnt <= spawn_cnt + 4'd1;
    end
  end

  assign bus.trail_x    = x_q;
  assign bus.trail_y    = y_q;
  assign bus.trail_life = life_q;

endmodule

// File: tb/tb_player_trail_gen.sv
// Self-checking bench for player_trail_gen: behavioural field model feeding a scoreboard,
// a table of directed slot checks, and hand sequences for wrap, pause/over, clamp, edge death
// and asynchronous reset.
module tb_player_trail_gen;
  import game_pkg::*;

  localparam int N            = 41;
  localparam int M_SPAWN_DIV  = 1;
  localparam int M_SPEED      = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  player_trail_gen_if #(.N_TRAIL(N)) bus ();
  player_trail_gen_if #(.N_TRAIL(N)) bus2 ();

  player_trail_gen #(
    .N_TRAIL(N), .LIFE_MAX(10), .TRAIL_SPEED(4), .SPAWN_DIV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Fast-drift instance: x goes 160 -> 81 -> 2, so a live particle lands below the speed
  player_trail_gen #(
    .N_TRAIL(N), .LIFE_MAX(10), .TRAIL_SPEED(79), .SPAWN_DIV(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct packed {
    logic [N-1:0][9:0] x;
    logic [N-1:0][8:0] y;
    logic [N-1:0][3:0] life;
  } field_t;

  typedef struct {
    logic [1:0] gm;
    logic [8:0] py;
    int         frames;
    int         slot;
    logic [9:0] ex;
    logic [8:0] ey;
    logic [3:0] el;
  } vec_t;

  int     n_checks = 0;
  int     n_pass   = 0;
  field_t sb_q[$];
  field_t sb_e;

  logic [9:0] m_x[N];
  logic [8:0] m_y[N];
  logic [3:0] m_life[N];
  int         m_wr;
  int         m_cnt;
  logic [3:0] m_lfsr;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int live_cnt(input logic [N-1:0][3:0] l);
    int c = 0;
    for (int i = 0; i < N; i++) if (l[i] != 4'd0) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = '0; m_y[i] = '0; m_life[i] = '0;
    end
    m_wr = 0; m_cnt = 0; m_lfsr = 4'b1001;
  endtask

  task automatic model_step(input logic [1:0] gm, input logic [8:0] py, input logic tick);
    int s;
    if (gm == GM_START) begin
      for (int i = 0; i < N; i++) m_life[i] = '0;
      m_wr = 0; m_cnt = 0;
    end else if (tick && (gm == GM_PLAY || gm == GM_OVER)) begin
      for (int i = 0; i < N; i++) begin
        if (m_life[i] != 0) begin
          if (int'(m_x[i]) < M_SPEED) m_life[i] = 0;
          else begin
            m_x[i]    = 10'(int'(m_x[i]) - M_SPEED);
            m_life[i] = m_life[i] - 4'd1;
          end
        end
      end
      if (gm == GM_PLAY) begin
        if (m_cnt == M_SPAWN_DIV - 1) begin
          s = int'(py) + 16 + int'(m_lfsr[2:0]);
          if (s < 21)  s = 21;
          if (s > 459) s = 459;
          m_x[m_wr]    = 10'd160;
          m_y[m_wr]    = 9'(s);
          m_life[m_wr] = 4'd10;
          m_wr   = (m_wr + 1) % N;
          m_lfsr = {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  function automatic field_t model_field();
    field_t f;
    for (int i = 0; i < N; i++) begin
      f.x[i] = m_x[i]; f.y[i] = m_y[i]; f.life[i] = m_life[i];
    end
    return f;
  endfunction

  // One clock of stimulus; the model's expected field is queued for the checker
  task automatic do_cycle(input logic [1:0] gm, input logic [8:0] py, input logic tick);
    @(negedge clk);
    bus.gamemode  = gm;  bus.player_y  = py;  bus.frame_tick  = tick;
    bus2.gamemode = gm;  bus2.player_y = py;  bus2.frame_tick = tick;
    model_step(gm, py, tick);
    sb_q.push_back(model_field());
  endtask

  task automatic frame(input logic [1:0] gm, input logic [8:0] py);
    do_cycle(gm, py, 1'b1);
    do_cycle(gm, py, 1'b0);
    do_cycle(gm, py, 1'b0);
  endtask

  // Scoreboard checker: after each edge compare the whole field against the oldest expectation
  always begin
    @(posedge clk);
    #1;
    if (rst_n && sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      chk("sb_trail_x",    512'(bus.trail_x),    512'(sb_e.x));
      chk("sb_trail_y",    512'(bus.trail_y),    512'(sb_e.y));
      chk("sb_trail_life", 512'(bus.trail_life), 512'(sb_e.life));
    end
  end

  vec_t vt[6];

  initial begin
    vt[0] = '{GM_PLAY, 9'd200, 1, 0, 10'd160, 9'd217, 4'd10};
    vt[1] = '{GM_PLAY, 9'd200, 5, 0, 10'd140, 9'd217, 4'd5};
    vt[2] = '{GM_PLAY, 9'd200, 0, 1, 10'd144, 9'd219, 4'd6};
    vt[3] = '{GM_PLAY, 9'd200, 0, 3, 10'd152, 9'd221, 4'd8};
    vt[4] = '{GM_PLAY, 9'd200, 0, 5, 10'd160, 9'd221, 4'd10};
    vt[5] = '{GM_PLAY, 9'd200, 0, 6, 10'd0,   9'd0,   4'd0};

    bus.gamemode  = GM_START; bus.player_y  = 9'd0; bus.frame_tick  = 1'b0;
    bus2.gamemode = GM_START; bus2.player_y = 9'd0; bus2.frame_tick = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("reset_x",    512'(bus.trail_x),    512'(0));
    chk("reset_y",    512'(bus.trail_y),    512'(0));
    chk("reset_life", 512'(bus.trail_life), 512'(0));
    rst_n = 1'b1;
    do_cycle(GM_START, 9'd200, 1'b1);
    do_cycle(GM_START, 9'd200, 1'b0);

    // Directed slot table
    for (int i = 0; i < 6; i++) begin
      repeat (vt[i].frames) frame(vt[i].gm, vt[i].py);
      chk("vec_x",    512'(bus.trail_x[vt[i].slot]),    512'(vt[i].ex));
      chk("vec_y",    512'(bus.trail_y[vt[i].slot]),    512'(vt[i].ey));
      chk("vec_life", 512'(bus.trail_life[vt[i].slot]), 512'(vt[i].el));
    end

    // 36 more spawns: the 42nd spawn wraps back into slot 0
    repeat (36) frame(GM_PLAY, 9'd200);
    chk("wrap_slot0_life",  512'(bus.trail_life[0]),  512'(10));
    chk("wrap_slot0_x",     512'(bus.trail_x[0]),     512'(160));
    chk("wrap_slot40_life", 512'(bus.trail_life[40]), 512'(9));
    chk("wrap_slot40_x",    512'(bus.trail_x[40]),    512'(156));
    chk("wrap_live_count",  512'(live_cnt(bus.trail_life)), 512'(10));
    repeat (3) frame(GM_PLAY, 9'd200);
    chk("steady_live_count", 512'(live_cnt(bus.trail_life)), 512'(10));

    // Pause freezes (scoreboard), game over fades out without spawning
    repeat (4) frame(GM_PAUSE, 9'd100);
    chk("pause_live_count", 512'(live_cnt(bus.trail_life)), 512'(10));
    repeat (10) frame(GM_OVER, 9'd100);
    chk("over_live_count", 512'(live_cnt(bus.trail_life)), 512'(0));

    // Start mode kills lives on the next edge without a tick, and rewinds the pointer
    repeat (2) frame(GM_PLAY, 9'd300);
    chk("pre_start_live", 512'(live_cnt(bus.trail_life)), 512'(2));
    do_cycle(GM_START, 9'd300, 1'b0);
    do_cycle(GM_START, 9'd300, 1'b0);
    chk("start_live", 512'(live_cnt(bus.trail_life)), 512'(0));
    frame(GM_PLAY, 9'd300);
    chk("start_ptr_slot0", 512'(bus.trail_life[0]), 512'(10));
    frame(GM_PLAY, 9'd300);

    // Asynchronous reset in the middle of a clock high phase
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_x",    512'(bus.trail_x),    512'(0));
    chk("async_y",    512'(bus.trail_y),    512'(0));
    chk("async_life", 512'(bus.trail_life), 512'(0));
    sb_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clamp at both bounds (seeded jitter 1 then 3)
    frame(GM_PLAY, 9'd0);
    chk("clamp_low_y", 512'(bus.trail_y[0]), 512'(21));
    frame(GM_PLAY, 9'd511);
    chk("clamp_high_y", 512'(bus.trail_y[1]), 512'(459));
    chk("fast_x_81",    512'(bus2.trail_x[0]), 512'(81));
    frame(GM_PLAY, 9'd200);
    chk("fast_x_2",     512'(bus2.trail_x[0]),    512'(2));
    chk("fast_life_8",  512'(bus2.trail_life[0]), 512'(8));
    frame(GM_PLAY, 9'd200);
    chk("edge_death_life", 512'(bus2.trail_life[0]), 512'(0));
    chk("edge_death_x",    512'(bus2.trail_x[0]),    512'(2));

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
